// File: rtl/eth_echo_responder.sv
// Far-end loopback responder: echoes matching Ethernet frames with MAC addresses swapped.
// Optional statistics counters are enabled by defining ECHO_RESP_STATS_EN.
module eth_echo_responder #(
  parameter logic [47:0] LOCAL_MAC_RESET = 48'h02_00_00_00_00_01
) (
  input  logic         ap_clk,
  input  logic         ap_rst_n,
  input  logic         s_axis_rx_tvalid,
  output logic         s_axis_rx_tready,
  input  logic [511:0] s_axis_rx_tdata,
  input  logic [63:0]  s_axis_rx_tkeep,
  input  logic         s_axis_rx_tlast,
  input  logic         s_axis_rx_tuser,
  output logic         m_axis_tx_tvalid,
  input  logic         m_axis_tx_tready,
  output logic [511:0] m_axis_tx_tdata,
  output logic [63:0]  m_axis_tx_tkeep,
  output logic         m_axis_tx_tlast,
  output logic         m_axis_tx_tuser,
  input  logic [47:0]  local_mac,
  input  logic [15:0]  ethertype,
  output logic [31:0]  fwd_count,
  output logic [31:0]  drop_count
);

  typedef enum logic [1:0] {HDR, FWD, DROP} state_t;

  state_t       state, state_next;
  logic         rx_accept;
  logic         hdr_match;
  logic         load;
  logic [511:0] hdr_data;

  // The reset-default MAC is documentation only; the live address is the local_mac port.
  logic unused_cfg;
  assign unused_cfg = ^LOCAL_MAC_RESET;

  assign rx_accept = s_axis_rx_tvalid && s_axis_rx_tready;

  always_comb begin
    hdr_match = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (s_axis_rx_tdata[8*i +: 8] != local_mac[47-8*i -: 8]) hdr_match = 1'b0;
    end
    if ({s_axis_rx_tdata[103:96], s_axis_rx_tdata[111:104]} != ethertype) hdr_match = 1'b0;
    if (!(&s_axis_rx_tkeep[13:0])) hdr_match = 1'b0;
  end

  always_comb begin
    hdr_data = s_axis_rx_tdata;
    for (int unsigned i = 0; i < 6; i++) begin
      hdr_data[8*i +: 8]     = s_axis_rx_tdata[8*(i+6) +: 8];
      hdr_data[8*(i+6) +: 8] = local_mac[47-8*i -: 8];
    end
  end

  // Only header-matched or mid-frame forwarded beats ever reach the output register.
  assign load = rx_accept && ((state == FWD) || ((state == HDR) && hdr_match));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= HDR;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HDR: begin
        if (rx_accept && !s_axis_rx_tlast) state_next = hdr_match ? FWD : DROP;
      end
      FWD, DROP: begin
        if (rx_accept && s_axis_rx_tlast) state_next = HDR;
      end
      default: state_next = HDR;
    endcase
  end

  always_comb begin
    s_axis_rx_tready = (state == DROP) || !m_axis_tx_tvalid || m_axis_tx_tready;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_axis_tx_tvalid <= 1'b0;
      m_axis_tx_tdata  <= '0;
      m_axis_tx_tkeep  <= '0;
      m_axis_tx_tlast  <= 1'b0;
      m_axis_tx_tuser  <= 1'b0;
    end else if (load) begin
      m_axis_tx_tvalid <= 1'b1;
      m_axis_tx_tdata  <= (state == HDR) ? hdr_data : s_axis_rx_tdata;
      m_axis_tx_tkeep  <= s_axis_rx_tkeep;
      m_axis_tx_tlast  <= s_axis_rx_tlast;
      m_axis_tx_tuser  <= s_axis_rx_tuser;
    end else if (m_axis_tx_tready) begin
      m_axis_tx_tvalid <= 1'b0;
    end
  end

`ifdef ECHO_RESP_STATS_EN
  logic [31:0] fwd_q, drop_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      fwd_q  <= '0;
      drop_q <= '0;
    end else if (rx_accept && s_axis_rx_tlast) begin
      if (load) begin
        if (fwd_q != '1) fwd_q <= fwd_q + 32'd1;
      end else begin
        if (drop_q != '1) drop_q <= drop_q + 32'd1;
      end
    end
  end

  assign fwd_count  = fwd_q;
  assign drop_count = drop_q;
`else
  assign fwd_count  = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_eth_echo_responder.sv
// Bench for eth_echo_responder: frame-level reference model with directed and random traffic.
module tb_eth_echo_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rx_tvalid, rx_tready, rx_tlast, rx_tuser;
  logic [511:0] rx_tdata;
  logic [63:0]  rx_tkeep;
  logic         tx_tvalid, tx_tready, tx_tlast, tx_tuser;
  logic [511:0] tx_tdata;
  logic [63:0]  tx_tkeep;
  logic [47:0]  local_mac;
  logic [15:0]  ethertype;
  logic [31:0]  fwd_count, drop_count;

  always #5 clk = ~clk;

  eth_echo_responder #(.LOCAL_MAC_RESET(48'h02_00_00_00_00_01)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_rx_tvalid(rx_tvalid), .s_axis_rx_tready(rx_tready),
    .s_axis_rx_tdata(rx_tdata), .s_axis_rx_tkeep(rx_tkeep),
    .s_axis_rx_tlast(rx_tlast), .s_axis_rx_tuser(rx_tuser),
    .m_axis_tx_tvalid(tx_tvalid), .m_axis_tx_tready(tx_tready),
    .m_axis_tx_tdata(tx_tdata), .m_axis_tx_tkeep(tx_tkeep),
    .m_axis_tx_tlast(tx_tlast), .m_axis_tx_tuser(tx_tuser),
    .local_mac(local_mac), .ethertype(ethertype),
    .fwd_count(fwd_count), .drop_count(drop_count)
  );

`ifdef ECHO_RESP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
    logic         u;
  } beat_t;

  beat_t in_q[$];
  beat_t exp_q[$];
  int    exp_fwd = 0, exp_drop = 0;
  int    n_cmp = 0, n_bad = 0;

  logic         hold_prev = 1'b0;
  logic [511:0] prev_data;
  logic [66:0]  prev_ctl;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mac_byte(input logic [47:0] m, input int i);
    return m[47-8*i -: 8];
  endfunction

  function automatic logic [63:0] keep_n(input int n);
    logic [63:0] k = '0;
    for (int i = 0; i < n; i++) k[i] = 1'b1;
    return k;
  endfunction

  // Reference model: decide the frame's fate from its fields, queue the expected echo.
  task automatic add_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                           input int nb, input logic [63:0] fkeep, input logic [63:0] lkeep,
                           input bit err);
    logic [63:0] first_keep;
    bit match;
    first_keep = (nb == 1) ? lkeep : fkeep;
    match = (dst == local_mac) && (et == ethertype) && (&first_keep[13:0]);
    for (int b = 0; b < nb; b++) begin
      beat_t x, e;
      for (int w = 0; w < 16; w++) x.d[32*w +: 32] = $urandom();
      if (b == 0) begin
        for (int i = 0; i < 6; i++) begin
          x.d[8*i +: 8]     = mac_byte(dst, i);
          x.d[8*(i+6) +: 8] = mac_byte(src, i);
        end
        x.d[103:96]  = et[15:8];
        x.d[111:104] = et[7:0];
      end
      x.k = (b == 0) ? first_keep : ((b == nb-1) ? lkeep : '1);
      x.l = (b == nb-1);
      x.u = err && (b == nb-1);
      in_q.push_back(x);
      if (match) begin
        e = x;
        if (b == 0) begin
          for (int i = 0; i < 6; i++) begin
            e.d[8*i +: 8]     = mac_byte(src, i);
            e.d[8*(i+6) +: 8] = mac_byte(local_mac, i);
          end
        end
        exp_q.push_back(e);
      end
    end
    if (match) exp_fwd++; else exp_drop++;
  endtask

  task automatic observe();
    if (hold_prev) begin
      chk("hold_data", tx_tdata, prev_data);
      chk("hold_ctl", 512'({tx_tvalid, tx_tkeep, tx_tlast, tx_tuser}), 512'(prev_ctl));
    end
    if (tx_tvalid && tx_tready) begin
      int avail = exp_q.size();
      chk("beat_expected", 512'(avail > 0), 512'(1));
      if (avail > 0) begin
        beat_t e = exp_q.pop_front();
        chk("tx_tdata", tx_tdata, e.d);
        chk("tx_tkeep", 512'(tx_tkeep), 512'(e.k));
        chk("tx_tlast", 512'(tx_tlast), 512'(e.l));
        chk("tx_tuser", 512'(tx_tuser), 512'(e.u));
      end
    end
    hold_prev = tx_tvalid && !tx_tready;
    prev_data = tx_tdata;
    prev_ctl  = {tx_tvalid, tx_tkeep, tx_tlast, tx_tuser};
  endtask

  // mode 0: tx_tready=1, 1: toggling 1010, 2: random. Called and returns at posedge+1.
  task automatic run(input int mode, input int vprob, input int stop_acc, input bit chk_rdy);
    int cyc = 0, acc = 0;
    bit pend = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < 2000 &&
           !(stop_acc > 0 && acc >= stop_acc)) begin
      if (!pend && in_q.size() > 0 && $urandom_range(99) < vprob) pend = 1;
      rx_tvalid = pend;
      if (pend) begin
        rx_tdata = in_q[0].d; rx_tkeep = in_q[0].k;
        rx_tlast = in_q[0].l; rx_tuser = in_q[0].u;
      end
      case (mode)
        0:       tx_tready = 1'b1;
        1:       tx_tready = (cyc % 2 == 0);
        default: tx_tready = 1'($urandom_range(1));
      endcase
      @(negedge clk);
      observe();
      if (chk_rdy) chk("rx_tready_high", 512'(rx_tready), 512'(1));
      if (rx_tvalid && rx_tready) begin
        void'(in_q.pop_front());
        pend = 0;
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rx_tvalid = 1'b0;
    if (cyc >= 2000) begin
      chk("timeout_pending", 512'(in_q.size() + exp_q.size()), 512'(0));
      in_q.delete();
      exp_q.delete();
    end
    if (stop_acc <= 0) begin
      tx_tready = 1'b1;
      repeat (3) begin
        @(negedge clk); observe();
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_fwd"}, 512'(fwd_count), 512'(STATS ? exp_fwd : 0));
    chk({tag, "_drop"}, 512'(drop_count), 512'(STATS ? exp_drop : 0));
  endtask

  initial begin
    rst_n = 1'b0; rx_tvalid = 1'b0; rx_tdata = '0; rx_tkeep = '0;
    rx_tlast = 1'b0; rx_tuser = 1'b0; tx_tready = 1'b1;
    local_mac = 48'h02_00_00_00_00_01; ethertype = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 512'(tx_tvalid), 512'(0));
    chk("rst_tdata", tx_tdata, '0);
    chk("rst_tkeep_last_user", 512'({tx_tkeep, tx_tlast, tx_tuser}), 512'(0));
    chk("rst_rx_tready", 512'(rx_tready), 512'(1));
    chk_counters("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 3-beat matching frame
    add_frame(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_00, 16'hFFFF, 3, '1, 64'h0000_0000_0000_FFFF, 0);
    run(0, 100, 0, 0);
    chk_counters("match3");

    // wrong destination, 2 beats
    add_frame(48'h02_00_00_00_00_07, 48'h02_00_00_00_00_00, 16'hFFFF, 2, '1, 64'hFF, 0);
    run(0, 100, 0, 1);
    chk_counters("wrong_dst");

    // runt single beat
    add_frame(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_00, 16'hFFFF, 1, '1, 64'h0FFF, 0);
    run(0, 100, 0, 1);
    chk_counters("runt");

    // error flag with toggling backpressure
    add_frame(48'h02_00_00_00_00_01, 48'h0A_0B_0C_0D_0E_0F, 16'hFFFF, 4, '1, keep_n(33), 1);
    run(1, 100, 0, 0);
    chk_counters("err_bp");

    // mixed back-to-back frames
    add_frame(48'h02_00_00_00_00_01, 48'h12_34_56_78_9A_BC, 16'hFFFF, 2, '1, keep_n(64), 0);
    add_frame(48'h02_00_00_00_00_01, 48'h12_34_56_78_9A_BC, 16'h0800, 2, '1, keep_n(20), 0);
    add_frame(48'h02_00_00_00_00_01, 48'h12_34_56_78_9A_BD, 16'hFFFF, 1, '1, keep_n(60), 0);
    add_frame(48'h02_00_00_00_00_01, 48'h12_34_56_78_9A_BE, 16'hFFFF, 3, '1, keep_n(1), 1);
    run(0, 100, 0, 1);
    chk_counters("b2b");

    // reset in the middle of a forwarded frame
    add_frame(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_09, 16'hFFFF, 4, '1, keep_n(8), 0);
    run(0, 100, 2, 0);
    chk("pre_reset_tvalid", 512'(tx_tvalid), 512'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", 512'(tx_tvalid), 512'(0));
    chk("midrst_rx_tready", 512'(rx_tready), 512'(1));
    chk("midrst_fwd", 512'(fwd_count), 512'(0));
    chk("midrst_drop", 512'(drop_count), 512'(0));
    in_q.delete(); exp_q.delete();
    exp_fwd = 0; exp_drop = 0; hold_prev = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    add_frame(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_0A, 16'hFFFF, 2, '1, keep_n(40), 0);
    run(0, 100, 0, 0);
    chk_counters("after_rst");

    // randomized traffic with new addressing
    local_mac = {$urandom(), 16'($urandom())};
    ethertype = 16'($urandom());
    for (int f = 0; f < 30; f++) begin
      logic [47:0] dst, src;
      logic [15:0] et;
      logic [63:0] fk;
      dst = ($urandom_range(1) == 1) ? local_mac : {$urandom(), 16'($urandom())};
      src = {$urandom(), 16'($urandom())};
      et  = ($urandom_range(9) < 8) ? ethertype : 16'($urandom());
      fk  = ($urandom_range(9) < 8) ? '1 : {$urandom(), $urandom()};
      add_frame(dst, src, et, $urandom_range(1, 4), fk, keep_n($urandom_range(1, 64)),
                1'($urandom_range(1)));
    end
    run(2, 70, 0, 0);
    chk_counters("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
